// File: rtl/qpp_pkg.sv
// qpp_pkg: constants and the elaboration-time index function for the LTE
// turbo-code QPP internal interleaver.
//   KMAX     : data bus width and largest block size (6144)
//   K_SMALL  : small block size (1056)
//   F1_/F2_  : QPP polynomial coefficients for each block size
//   qpp_index(i, k, f1, f2) returns pi(i) = (f1*i + f2*i*i) mod k
package qpp_pkg;

  localparam int KMAX     = 6144;
  localparam int K_SMALL  = 1056;
  localparam int F1_SMALL = 17;
  localparam int F2_SMALL = 66;
  localparam int F1_LARGE = 263;
  localparam int F2_LARGE = 480;

  // f2*i*i reaches roughly 1.8e10 for K = 6144, so the arithmetic is done
  // in 64 bits before the modulo brings it back into index range.
  function automatic int qpp_index(input int i, input int k, input int f1, input int f2);
    longint li;
    longint t;
    li = longint'(i);
    t  = (longint'(f1) * li + longint'(f2) * li * li) % longint'(k);
    return int'(t);
  endfunction

endpackage

// File: rtl/qpp_perm.sv
// qpp_perm: purely combinational QPP permutation network.
//   cin       : input block, bit i of the block is cin[i]
//   k_eq_6144 : 1 selects K = 6144, 0 selects K = 1056
//   perm      : permuted block, perm[i] = cin[pi(i)]; bits >= K are 0
// All indices are fixed at elaboration, so the network is pure wiring plus
// a final 2:1 select.
module qpp_perm
  import qpp_pkg::*;
(
  input  logic [KMAX-1:0] cin,
  input  logic            k_eq_6144,
  output logic [KMAX-1:0] perm
);

  logic [KMAX-1:0] w_perm_l;
  logic [KMAX-1:0] w_perm_s;

  for (genvar i = 0; i < KMAX; i++) begin : g_large
    localparam int P = qpp_index(i, KMAX, F1_LARGE, F2_LARGE);
    assign w_perm_l[i] = cin[P];
  end

  // Small blocks only ever read cin[K_SMALL-1:0]; the upper input bits are
  // never routed here, and the upper output bits are tied low.
  for (genvar i = 0; i < K_SMALL; i++) begin : g_small
    localparam int P = qpp_index(i, K_SMALL, F1_SMALL, F2_SMALL);
    assign w_perm_s[i] = cin[P];
  end
  assign w_perm_s[KMAX-1:K_SMALL] = '0;

  always_comb begin
    perm = k_eq_6144 ? w_perm_l : w_perm_s;
  end

endmodule

// File: rtl/qpp_interleaver.sv
// qpp_interleaver: block-level LTE turbo-code QPP interleaver with a
// registered output and a one-cycle valid handshake.
//   clk       : rising-edge clock
//   reset_n   : asynchronous active-low reset
//   in_valid  : cin/k_eq_6144 valid this cycle
//   k_eq_6144 : 1 = K 6144, 0 = K 1056
//   cin       : input block (LSB = bit 0)
//   cout      : registered interleaved block, holds when in_valid = 0
//   out_valid : cout was loaded on the last clock edge
//   k_out     : block size used for the block on cout
module qpp_interleaver
  import qpp_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  input  logic            k_eq_6144,
  input  logic [KMAX-1:0] cin,
  output logic [KMAX-1:0] cout,
  output logic            out_valid,
  output logic            k_out
);

  logic [KMAX-1:0] w_perm;
  logic [KMAX-1:0] r_cout;
  logic            r_valid;
  logic            r_k;

  qpp_perm u_perm (
    .cin       (cin),
    .k_eq_6144 (k_eq_6144),
    .perm      (w_perm)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cout  <= '0;
      r_valid <= 1'b0;
      r_k     <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_cout <= w_perm;
        r_k    <= k_eq_6144;
      end
    end
  end

  assign cout      = r_cout;
  assign out_valid = r_valid;
  assign k_out     = r_k;

endmodule

// File: tb/tb_qpp_interleaver.sv
module tb_qpp_interleaver;

  localparam int N = 6144;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         k_eq_6144;
  logic [N-1:0] cin;
  logic [N-1:0] cout;
  logic         out_valid;
  logic         k_out;

  int checks   = 0;
  int failures = 0;

  // Reference state: what the outputs must show after the latest edge.
  logic [N-1:0] m_cout  = '0;
  logic         m_valid = 1'b0;
  logic         m_k     = 1'b0;

  qpp_interleaver dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .k_eq_6144 (k_eq_6144),
    .cin       (cin),
    .cout      (cout),
    .out_valid (out_valid),
    .k_out     (k_out)
  );

  always #5 clk = ~clk;

  // Direct evaluation of c'_i = c_pi(i), pi(i) = (f1*i + f2*i^2) mod K.
  function automatic logic [N-1:0] ref_perm(input logic [N-1:0] c, input logic big);
    logic [N-1:0] r;
    longint kk, f1, f2, p;
    r  = '0;
    kk = big ? 64'd6144 : 64'd1056;
    f1 = big ? 64'd263  : 64'd17;
    f2 = big ? 64'd480  : 64'd66;
    for (longint i = 0; i < kk; i++) begin
      p = (f1 * i + f2 * i * i) % kk;
      r[int'(i)] = c[int'(p)];
    end
    return r;
  endfunction

  function automatic logic [N-1:0] rand_vec();
    logic [N-1:0] r;
    for (int j = 0; j < N / 32; j++) r[j*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic check_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic check_vec(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
    logic [N-1:0] d;
    int first;
    checks++;
    d = got ^ exp;
    if (d !== '0) begin
      failures++;
      first = -1;
      for (int j = 0; j < N; j++) if (d[j] !== 1'b0 && first < 0) first = j;
      $display("FAIL %s: first bad bit %0d got %b expected %b, %0d bits differ, t=%0t",
               name, first, got[first], exp[first], $countones(d), $time);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference register behaviour.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_cout  = '0;
      m_valid = 1'b0;
      m_k     = 1'b0;
    end else begin
      m_valid = in_valid;
      if (in_valid) begin
        m_cout = ref_perm(cin, k_eq_6144);
        m_k    = k_eq_6144;
      end
    end
  end

  // Every-cycle comparison.
  always @(negedge clk) begin
    check_bit("out_valid", out_valid, m_valid);
    check_bit("k_out", k_out, m_k);
    check_vec("cout", cout, m_cout);
  end

  // Apply one block for one cycle, then drop in_valid; returns after the
  // negedge where the block is visible on the outputs.
  task automatic pulse(input logic big, input logic [N-1:0] c);
    @(negedge clk);
    in_valid  = 1'b1;
    k_eq_6144 = big;
    cin       = c;
    @(negedge clk);
    in_valid  = 1'b0;
    #1;
  endtask

  task automatic onehot(input string name, input logic big, input int src, input int dst);
    logic [N-1:0] c, e;
    c = '0; c[src] = 1'b1;
    e = '0; e[dst] = 1'b1;
    pulse(big, c);
    check_vec(name, cout, e);
    check_bit({name, "_valid"}, out_valid, 1'b1);
    @(negedge clk); #1;
    check_bit({name, "_valid_drop"}, out_valid, 1'b0);
    check_vec({name, "_hold"}, cout, e);
  endtask

  initial begin
    logic [N-1:0] a, b, lo_mask, e;
    logic big;

    // Reset held with garbage input.
    reset_n   = 1'b0;
    in_valid  = 1'b1;
    k_eq_6144 = 1'b1;
    cin       = '1;
    repeat (4) @(negedge clk);
    #1;
    check_vec("reset_cout", cout, '0);
    check_bit("reset_valid", out_valid, 1'b0);
    in_valid = 1'b0;
    reset_n  = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_vec("post_reset_cout", cout, '0);
    check_bit("post_reset_k", k_out, 1'b0);

    // Hand-computed indices: pi_S(1)=83, pi_S(2)=298, pi_L(1)=743, pi_L(2)=2446.
    onehot("s_bit1", 1'b0, 83, 1);
    onehot("s_bit2", 1'b0, 298, 2);
    onehot("l_bit1", 1'b1, 743, 1);
    onehot("l_bit2", 1'b1, 2446, 2);

    // Small mode ignores upper input bits and zeroes upper output bits.
    lo_mask = '0;
    lo_mask[1055:0] = '1;
    pulse(1'b0, ~lo_mask);
    check_vec("s_upper_garbage", cout, '0);
    pulse(1'b0, '1);
    check_vec("s_all_ones", cout, lo_mask);

    // Random blocks: popcount preserved over the active K bits.
    for (int t = 0; t < 8; t++) begin
      big = t[0];
      a = rand_vec();
      pulse(big, a);
      check_int("popcount", $countones(cout),
                big ? $countones(a) : $countones(a & lo_mask));
    end

    // Back-to-back with mode toggle.
    a = rand_vec();
    b = rand_vec();
    @(negedge clk);
    in_valid = 1'b1; k_eq_6144 = 1'b1; cin = a;
    @(negedge clk);
    in_valid = 1'b1; k_eq_6144 = 1'b0; cin = b;
    #1;
    check_bit("b2b_k_A", k_out, 1'b1);
    @(negedge clk);
    in_valid = 1'b0; cin = rand_vec();
    #1;
    check_bit("b2b_k_B", k_out, 1'b0);
    check_bit("b2b_valid_B", out_valid, 1'b1);
    @(negedge clk); #1;
    check_bit("b2b_valid_low", out_valid, 1'b0);

    // Random traffic: valid, mode and data all randomized.
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      k_eq_6144 = $urandom_range(0, 1) != 0;
      cin       = rand_vec();
    end
    @(negedge clk);
    in_valid = 1'b0;

    // Asynchronous reset mid-cycle clears outputs without a clock edge.
    e = rand_vec();
    e[0] = 1'b1;
    pulse(1'b1, e);
    check_bit("cout0_eq_cin0", cout[0], 1'b1);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_vec("async_reset_cout", cout, '0);
    check_bit("async_reset_valid", out_valid, 1'b0);
    check_bit("async_reset_k", k_out, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
